// File: rtl/key_note_encoder.sv
// Turns keyboard scan bytes into note-on / note-off events with last-note priority.
// Z/X keys step a saturating octave register that is latched only when a note is announced.
module key_note_encoder #(
    parameter int OCT_RESET = 4,
    parameter int OCT_MAX   = 6
) (
    input  logic       clk,
    input  logic       reset,
    // scan_valid is a one-cycle strobe with no back-pressure: every cycle it
    // is high, scan_code is consumed at that posedge.
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       note_in,
    output logic [3:0] note,
    output logic [2:0] octave,
    output logic       note_off,
    output logic       key_held,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [2:0] OCT_RST_V = 3'(OCT_RESET);
    localparam logic [2:0] OCT_MAX_V = 3'(OCT_MAX);
    localparam logic [7:0] CODE_BRK  = 8'hF0;
    localparam logic [7:0] CODE_EXT  = 8'hE0;
    localparam logic [7:0] CODE_DN   = 8'h1A;
    localparam logic [7:0] CODE_UP   = 8'h22;

    state_t     state, state_d;
    logic [2:0] oct_reg, oct_reg_d;
    logic [7:0] held_code, held_code_d;
    logic       key_held_d, note_in_d, note_off_d;
    logic [3:0] note_d;
    logic [2:0] octave_d;
    logic       code_mapped;
    logic [3:0] code_note;

    assign fsm_state = state;

    always_comb begin
        code_mapped = 1'b1;
        code_note   = 4'd0;
        case (scan_code)
            8'h1C: code_note = 4'd0;
            8'h1D: code_note = 4'd1;
            8'h1B: code_note = 4'd2;
            8'h24: code_note = 4'd3;
            8'h23: code_note = 4'd4;
            8'h2B: code_note = 4'd5;
            8'h2C: code_note = 4'd6;
            8'h34: code_note = 4'd7;
            8'h35: code_note = 4'd8;
            8'h33: code_note = 4'd9;
            8'h3C: code_note = 4'd10;
            8'h3B: code_note = 4'd11;
            default: code_mapped = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state;
        oct_reg_d   = oct_reg;
        held_code_d = held_code;
        key_held_d  = key_held;
        note_d      = note;
        octave_d    = octave;
        note_in_d   = 1'b0;
        note_off_d  = 1'b0;
        if (scan_valid) begin
            case (state)
                IDLE: begin
                    if (scan_code == CODE_BRK) begin
                        state_d = BRK;
                    end else if (scan_code == CODE_EXT) begin
                        state_d = EXT;
                    end else begin
                        if (scan_code == CODE_DN && oct_reg != 3'd0)
                            oct_reg_d = oct_reg - 3'd1;
                        if (scan_code == CODE_UP && oct_reg < OCT_MAX_V)
                            oct_reg_d = oct_reg + 3'd1;
                        // A repeat of the held key is typematic and must not retrigger.
                        if (code_mapped && (!key_held || scan_code != held_code)) begin
                            note_in_d   = 1'b1;
                            note_d      = code_note;
                            octave_d    = oct_reg;
                            key_held_d  = 1'b1;
                            held_code_d = scan_code;
                        end
                    end
                end
                BRK: begin
                    if (scan_code == CODE_BRK) begin
                        state_d = BRK;
                    end else begin
                        state_d = IDLE;
                        if (code_mapped && key_held && scan_code == held_code) begin
                            note_off_d = 1'b1;
                            key_held_d = 1'b0;
                        end
                    end
                end
                EXT: state_d = (scan_code == CODE_BRK) ? EXT_BRK : IDLE;
                EXT_BRK: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            oct_reg   <= OCT_RST_V;
            held_code <= 8'h00;
            key_held  <= 1'b0;
            note      <= 4'd0;
            octave    <= OCT_RST_V;
            note_in   <= 1'b0;
            note_off  <= 1'b0;
        end else begin
            state     <= state_d;
            oct_reg   <= oct_reg_d;
            held_code <= held_code_d;
            key_held  <= key_held_d;
            note      <= note_d;
            octave    <= octave_d;
            note_in   <= note_in_d;
            note_off  <= note_off_d;
        end
    end

endmodule
